qe_ctrl: RTL and testbench

Clocked controller for a 16-bit quadrature position counter on a PIC16 CLB-style fabric.
- Synchronises and glitch-filters the raw i/q encoder lines.
- Decodes x4 quadrature steps, maintains position, flags illegal transitions, and computes per-period velocity.
- Raises compare/error interrupts.
- Provides an 8-bit byte-serial read port with atomic 16-bit shadowing for the 8-bit core.

---
 rtl/qe_ctrl_if.sv | 9 +
 rtl/qe_ctrl.sv | 81 ++++++++
 tb/tb_qe_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/qe_ctrl_if.sv
// qe_ctrl_if: byte-serial read port between the 8-bit core and the quadrature controller
interface qe_ctrl_if;
  logic       rd_req;
  logic [1:0] rd_sel;
  logic       rd_ack;
  logic [7:0] rd_data;
  modport master (output rd_req, rd_sel, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_sel, output rd_ack, rd_data);
endinterface

// File: rtl/qe_ctrl.sv
// qe_ctrl: filtered x4 quadrature decoder with position, velocity, interrupts and shadowed byte read port
module qe_ctrl #(
  parameter int FILT  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i,
  input  logic             q,
  input  logic             zero,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] cmp,
  input  logic             irq_clr,
  qe_ctrl_if.slave         rd,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] vel,
  output logic             dir,
  output logic             err,
  output logic             irq
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [1:0] s1_q, s2_q, last_q, last_d, acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic init_q, init_d, up_q, up_d, dn_q, dn_d, bad_q, bad_d, acc_ok, hit, cap;
  logic [CNT_W-1:0] pos_q, pos_d, step_pos, vel_q, vel_d, snap_q, snap_d, tmr_q, tmr_d;
  logic dir_q, dir_d, err_q, err_d, irq_q, irq_d, ack_q, ack_d;
  logic [7:0] rdat_q, rdat_d, psh_q, psh_d, vsh_q, vsh_d;
  always_ff @(posedge clk) begin
    s1_q <= {i, q};
    s2_q <= s1_q;
  end
  always_comb begin
    last_d   = s2_q;
    cnt_inc  = (s2_q == acc_q) ? 4'd0 : (s2_q != last_q) ? 4'd1 : cnt_q + 4'd1;
    acc_ok   = !init_q && s2_q != acc_q && cnt_inc == 4'(FILT);
    acc_d    = (init_q || acc_ok) ? s2_q : acc_q;
    cnt_d    = (init_q || acc_ok) ? 4'd0 : cnt_inc;
    init_d   = 1'b0;
    // up order 00->10->11->01: successor of {a,b} is {~b,a}
    up_d     = acc_ok && s2_q == {~acc_q[0], acc_q[1]};
    dn_d     = acc_ok && acc_q == {~s2_q[0], s2_q[1]};
    bad_d    = acc_ok && (s2_q ^ acc_q) == 2'b11;
    step_pos = up_q ? pos_q + ONE : dn_q ? pos_q - ONE : pos_q;
    pos_d    = zero ? '0 : step_pos;
    dir_d    = zero ? dir_q : up_q ? 1'b1 : dn_q ? 1'b0 : dir_q;
    hit      = !zero && (up_q || dn_q) && step_pos == cmp;
    err_d    = bad_q || (err_q && !irq_clr);
    irq_d    = hit || (bad_q && !err_q) || (irq_q && !irq_clr);
    cap      = period != '0 && tmr_q >= period - ONE;
    tmr_d    = (period == '0 || cap) ? '0 : tmr_q + ONE;
    vel_d    = cap ? pos_d - snap_q : vel_q;
    snap_d   = cap ? pos_d : zero ? '0 : snap_q;
    ack_d    = rd.rd_req;
    rdat_d   = !rd.rd_req ? rdat_q : rd.rd_sel == 2'd0 ? pos_q[7:0] : rd.rd_sel == 2'd1 ? psh_q :
               rd.rd_sel == 2'd2 ? vel_q[7:0] : vsh_q;
    psh_d    = (rd.rd_req && rd.rd_sel == 2'd0) ? pos_q[15:8] : psh_q;
    vsh_d    = (rd.rd_req && rd.rd_sel == 2'd2) ? vel_q[15:8] : vsh_q;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      last_q <= '0; acc_q <= '0; cnt_q <= '0; init_q <= 1'b1;
      up_q <= 1'b0; dn_q <= 1'b0; bad_q <= 1'b0;
      pos_q <= '0; vel_q <= '0; snap_q <= '0; tmr_q <= '0;
      dir_q <= 1'b0; err_q <= 1'b0; irq_q <= 1'b0;
      ack_q <= 1'b0; rdat_q <= '0; psh_q <= '0; vsh_q <= '0;
    end else begin
      last_q <= last_d; acc_q <= acc_d; cnt_q <= cnt_d; init_q <= init_d;
      up_q <= up_d; dn_q <= dn_d; bad_q <= bad_d;
      pos_q <= pos_d; vel_q <= vel_d; snap_q <= snap_d; tmr_q <= tmr_d;
      dir_q <= dir_d; err_q <= err_d; irq_q <= irq_d;
      ack_q <= ack_d; rdat_q <= rdat_d; psh_q <= psh_d; vsh_q <= vsh_d;
    end
  end
  assign pos = pos_q;
  assign vel = vel_q;
  assign dir = dir_q;
  assign err = err_q;
  assign irq = irq_q;
  assign rd.rd_ack  = ack_q;
  assign rd.rd_data = rdat_q;
endmodule

// File: tb/tb_qe_ctrl.sv
// tb_qe_ctrl: directed bench for qe_ctrl with a read-data scoreboard
module tb_qe_ctrl;
  logic clk = 1'b0, clr_n = 1'b0, i = 1'b0, q = 1'b0, zero = 1'b0, irq_clr = 1'b0;
  logic [15:0] period = 16'h0, cmp = 16'h8000;
  logic [15:0] pos, vel;
  logic dir, err, irq;
  int total = 0, bad = 0;
  logic [7:0] sbq[$];
  logic [1:0] st = 2'b00;
  logic [15:0] mpos = 16'h0;
  qe_ctrl_if rif();
  qe_ctrl #(.FILT(3), .CNT_W(16)) dut (
    .clk(clk), .clr_n(clr_n), .i(i), .q(q), .zero(zero), .period(period), .cmp(cmp),
    .irq_clr(irq_clr), .rd(rif.slave), .pos(pos), .vel(vel), .dir(dir), .err(err), .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic step(input bit up, input int h);
    st = up ? {~st[0], st[1]} : {st[0], ~st[1]};
    {i, q} = st;
    mpos = up ? mpos + 16'd1 : mpos - 16'd1;
    cyc(h);
  endtask
  task automatic take();
    chk("rd_ack", {31'd0, rif.rd_ack}, 32'd1);
    if (rif.rd_ack && sbq.size() > 0) chk("rd_data", {24'd0, rif.rd_data}, {24'd0, sbq.pop_front()});
  endtask
  task automatic rd1(input logic [1:0] sel, input logic [7:0] exp);
    rif.rd_sel = sel; rif.rd_req = 1'b1; sbq.push_back(exp);
    cyc(1);
    rif.rd_req = 1'b0;
    take();
  endtask
  initial begin
    rif.rd_req = 1'b0; rif.rd_sel = 2'd0;
    cyc(5);
    chk("rst_pos", {16'd0, pos}, 0); chk("rst_vel", {16'd0, vel}, 0);
    chk("rst_flags", {27'd0, dir, err, irq, rif.rd_ack, 1'b0}, 0);
    chk("rst_rdata", {24'd0, rif.rd_data}, 0);
    clr_n = 1'b1;
    cyc(5);
    st = 2'b10; {i, q} = st; mpos = 16'd1;
    cyc(5);
    chk("lat_before", {16'd0, pos}, 0);
    cyc(1);
    chk("lat_at6", {16'd0, pos}, 1);
    cyc(4);
    repeat (7) step(1'b1, 10);
    chk("up8_pos", {16'd0, pos}, 32'h8);
    chk("up8_dir", {31'd0, dir}, 1);
    chk("up8_err", {31'd0, err}, 0);
    zero = 1'b1; cyc(1); zero = 1'b0; mpos = 0; cyc(2);
    chk("zero_pos", {16'd0, pos}, 0);
    step(1'b0, 10);
    chk("dn_pos", {16'd0, pos}, 32'hFFFF);
    chk("dn_dir", {31'd0, dir}, 0);
    cmp = 16'h0001;
    step(1'b1, 10);
    chk("wrap_pos", {16'd0, pos}, 0);
    chk("irq_nohit", {31'd0, irq}, 0);
    step(1'b1, 10);
    chk("cmp_pos", {16'd0, pos}, 1);
    chk("cmp_irq", {31'd0, irq}, 1);
    irq_clr = 1'b1; cyc(1); irq_clr = 1'b0;
    chk("irq_clr", {31'd0, irq}, 0);
    i = ~st[1]; cyc(2); i = st[1]; cyc(10);
    chk("glitch_pos", {16'd0, pos}, {16'd0, mpos});
    chk("glitch_err", {31'd0, err}, 0);
    st = st ^ 2'b11; {i, q} = st; cyc(10);
    chk("ill_err", {31'd0, err}, 1);
    chk("ill_irq", {31'd0, irq}, 1);
    chk("ill_pos", {16'd0, pos}, {16'd0, mpos});
    irq_clr = 1'b1; cyc(1); irq_clr = 1'b0;
    chk("ill_clr", {30'd0, err, irq}, 0);
    cmp = 16'h8000; period = 16'd100; zero = 1'b1; cyc(1); zero = 1'b0; mpos = 0;
    repeat (25) step(1'b1, 3);
    cyc(29);
    chk("vel_up", {16'd0, vel}, 32'h0019);
    repeat (5) step(1'b0, 10);
    cyc(50);
    chk("vel_dn", {16'd0, vel}, 32'hFFFB);
    period = 16'd0;
    repeat (3) step(1'b1, 10);
    cyc(10);
    chk("vel_hold", {16'd0, vel}, 32'hFFFB);
    while (mpos != 16'h1234) step(1'b1, 3);
    cyc(10);
    chk("pos1234", {16'd0, pos}, 32'h1234);
    rd1(2'd0, 8'h34);
    cyc(1);
    chk("ack_one", {31'd0, rif.rd_ack}, 0);
    while (mpos != 16'h1300) step(1'b1, 3);
    cyc(10);
    rd1(2'd1, 8'h12);
    rif.rd_sel = 2'd2; rif.rd_req = 1'b1; sbq.push_back(8'hFB);
    cyc(1);
    take();
    rif.rd_sel = 2'd3; sbq.push_back(8'hFF);
    cyc(1);
    rif.rd_req = 1'b0;
    take();
    cyc(1);
    chk("b2b_end", {31'd0, rif.rd_ack}, 0);
    st = {~st[0], st[1]}; {i, q} = st;
    cyc(5);
    zero = 1'b1; cyc(1); zero = 1'b0; mpos = 0;
    chk("zstep_pos", {16'd0, pos}, 0);
    cyc(5);
    chk("zstep_hold", {16'd0, pos}, 0);
    period = 16'd10; cyc(15);
    chk("snap_zero", {16'd0, vel}, 0);
    step(1'b1, 10);
    chk("pre_rst_pos", {16'd0, pos}, 1);
    rif.rd_sel = 2'd0; rif.rd_req = 1'b1; clr_n = 1'b0;
    cyc(1);
    rif.rd_req = 1'b0;
    chk("mrst_ack", {31'd0, rif.rd_ack}, 0);
    chk("mrst_rdata", {24'd0, rif.rd_data}, 0);
    chk("mrst_pos", {16'd0, pos}, 0);
    chk("mrst_vel", {16'd0, vel}, 0);
    chk("mrst_flags", {29'd0, dir, err, irq}, 0);
    clr_n = 1'b1;
    cyc(2);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
